serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor: accepts two WIDTH-bit operands on a start pulse and computes `a - b` LSB-first, one bit per clock, through a single full-adder cell with inverted `b` and carry-in preset to 1. It is the subtracting counterpart of the team's full-adder datapath cell and is used in area-constrained arithmetic paths. A done pulse marks the result as valid, and the result holds until the next operation completes.

---
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result bundle for the bit-serial subtractor.
// Optional macro: SERIAL_SUB_OVERFLOW_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement a - b, LSB first, through one
// full-adder cell with b inverted and carry-in preset to 1.
// Optional macro: SERIAL_SUB_OVERFLOW_EN adds the ovf output and its flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave sub
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Full-adder helpers shared with the adder datapath cell.
  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-2:0] res_r;
  logic [CW-1:0]    cnt_r;
  logic             c_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_r;
`endif

  logic             b_inv_s;
  logic             sum_s;
  logic             carry_s;
  logic [WIDTH-1:0] res_shift_s;

  // Single full-adder cell: current bit of a plus inverted bit of b plus carry.
  always_comb begin
    b_inv_s     = ~b_r[0];
    sum_s       = fa_sum(a_r[0], b_inv_s, c_r);
    carry_s     = fa_carry(a_r[0], b_inv_s, c_r);
    res_shift_s = {sum_s, res_r};
  end

  // Control FSM, operand shift registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      res_r    <= {(WIDTH-1){1'b0}};
      cnt_r    <= {CW{1'b0}};
      c_r      <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      // Status flags trail the state by one edge so busy and done drop together.
      busy_r <= (state_r != IDLE);
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (sub.start) begin
            a_r     <= sub.a;
            b_r     <= sub.b;
            c_r     <= 1'b1;
            cnt_r   <= {CW{1'b0}};
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_r   <= a_r >> 1;
          b_r   <= b_r >> 1;
          c_r   <= carry_s;
          res_r <= res_shift_s[WIDTH-1:1];
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_BIT) begin
            // c_r here is the carry into the MSB stage, carry_s the final carry.
            state_r  <= DONE;
            diff_r   <= res_shift_s;
            borrow_r <= ~carry_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_r    <= c_r ^ carry_s;
`endif
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign sub.busy       = busy_r;
  assign sub.done       = done_r;
  assign sub.diff       = diff_r;
  assign sub.borrow_out = borrow_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign sub.ovf        = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed, scoreboarded bench for serial_subtractor
// with WIDTH=8. Honours SERIAL_SUB_OVERFLOW_EN for the ovf checks.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  serial_subtractor_if #(.WIDTH(W)) intf ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .sub (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.d  = av - bv;
    e.bo = (av < bv);
    e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
    return e;
  endfunction

  // Pop the oldest expectation and compare the result outputs against it.
  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_diff"}, 32'(intf.diff), 32'(e.d));
      chk({tag, "_borrow"}, 32'(intf.borrow_out), 32'(e.bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk({tag, "_ovf"}, 32'(intf.ovf), 32'(e.ov));
`endif
    end
  endtask

  // One full operation; intrude_k >= 0 pulses start with 0xFF-0xFF so that
  // it is sampled on edge T+intrude_k+1 while the DUT is busy.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int intrude_k);
    sb.push_back(model(av, bv));
    intf.start = 1'b1;
    intf.a     = av;
    intf.b     = bv;
    step();
    intf.start = 1'b0;
    intf.a     = 8'($urandom);
    intf.b     = 8'($urandom);
    for (int k = 0; k <= W + 2; k++) begin
      if (k > 0) begin
        step();
        intf.start = 1'b0;
      end
      chk({tag, "_busy"}, 32'(intf.busy), 32'((k >= 1) && (k <= W + 1)));
      chk({tag, "_done"}, 32'(intf.done), 32'(k == W + 1));
      if (intf.done === 1'b1) check_result(tag);
      if (k == intrude_k) begin
        intf.start = 1'b1;
        intf.a     = 8'hFF;
        intf.b     = 8'hFF;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    intf.start  = 1'b1;
    intf.a      = 8'h12;
    intf.b      = 8'h34;
    step();
    step();
    // Reset state; start coincident with rst must be ignored.
    chk("rst_busy", 32'(intf.busy), 32'd0);
    chk("rst_done", 32'(intf.done), 32'd0);
    chk("rst_diff", 32'(intf.diff), 32'd0);
    chk("rst_borrow", 32'(intf.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_ovf", 32'(intf.ovf), 32'd0);
`endif
    intf.start = 1'b0;
    rst        = 1'b0;
    step();
    chk("rst_start_ignored", 32'(intf.busy), 32'd0);
    step();
    chk("rst_start_ignored2", 32'(intf.busy), 32'd0);

    // Basic subtractions, including a borrow and zero operands.
    run_op("s5m3", 8'h05, 8'h03, -1);
    run_op("s3m5", 8'h03, 8'h05, -1);
    run_op("s0m0", 8'h00, 8'h00, -1);
    run_op("sffm01", 8'hFF, 8'h01, -1);

    // Start while busy is ignored; exactly one done follows.
    run_op("busy_ign", 8'h10, 8'h01, 2);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("no_second_done", 32'(intf.done), 32'd0);
      chk("no_second_busy", 32'(intf.busy), 32'd0);
    end

    // Reset mid-operation aborts with all outputs cleared and no done.
    run_op("pre_abort", 8'h05, 8'h03, -1);
    intf.start = 1'b1;
    intf.a     = 8'hAA;
    intf.b     = 8'h55;
    step();
    intf.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("abort_busy", 32'(intf.busy), 32'd1);
      chk("abort_done", 32'(intf.done), 32'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy0", 32'(intf.busy), 32'd0);
    chk("abort_done0", 32'(intf.done), 32'd0);
    chk("abort_diff0", 32'(intf.diff), 32'd0);
    chk("abort_borrow0", 32'(intf.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("abort_ovf0", 32'(intf.ovf), 32'd0);
`endif
    for (int k = 0; k < 12; k++) begin
      step();
      chk("abort_no_done", 32'(intf.done), 32'd0);
      chk("abort_idle", 32'(intf.busy), 32'd0);
    end
    run_op("after_abort", 8'h44, 8'h11, -1);

    // start held high re-triggers every W+2 cycles.
    for (int i = 0; i < 3; i++) sb.push_back(model(8'h0A, 8'h01));
    intf.start = 1'b1;
    intf.a     = 8'h0A;
    intf.b     = 8'h01;
    step();
    for (int k = 0; k <= 31; k++) begin
      if (k > 0) step();
      chk("hold_busy", 32'(intf.busy), 32'(((k % 10) != 0) && (k < 30)));
      chk("hold_done", 32'(intf.done), 32'(((k % 10) == 9) && (k < 30)));
      if (intf.done === 1'b1) check_result("hold");
      if (k >= 9) chk("hold_diff_stable", 32'(intf.diff), 32'h09);
      if (k == 25) intf.start = 1'b0;
    end

    // Signed-overflow corner cases.
    run_op("ov80m01", 8'h80, 8'h01, -1);
    run_op("ov7fmff", 8'h7F, 8'hFF, -1);
    run_op("ov05m03", 8'h05, 8'h03, -1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
